// File: rtl/node_pkg.sv
// Shared types and helpers for the neuron node family: state encoding,
// constant-width math helpers and the signed clamp used by the activations.
package node_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, ACT, HOLD} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int beats(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  function automatic logic signed [31:0] sclamp(input logic signed [31:0] v,
                                                input logic signed [31:0] lo,
                                                input logic signed [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/node_seq_mac_lanes.sv
// LANES-wide signed multiply and sum for one beat; masked lanes contribute zero.
// Purely combinational, no flow control.
module mac_lanes #(
  parameter int LANES       = 4,
  parameter int INPUT_BITS  = 3,
  parameter int WEIGHT_BITS = 3,
  parameter int ACC_BITS    = 16
) (
  input  logic [LANES*INPUT_BITS-1:0]  x,
  input  logic [LANES*WEIGHT_BITS-1:0] w,
  input  logic [LANES-1:0]             mask,
  output logic signed [ACC_BITS-1:0]   sum
);

  localparam int PW = INPUT_BITS + WEIGHT_BITS;

  always_comb begin
    logic signed [INPUT_BITS-1:0]  xi;
    logic signed [WEIGHT_BITS-1:0] wi;
    logic signed [PW-1:0]          p;
    xi  = '0;
    wi  = '0;
    p   = '0;
    sum = '0;
    for (int j = 0; j < LANES; j++) begin
      xi = x[j*INPUT_BITS +: INPUT_BITS];
      wi = w[j*WEIGHT_BITS +: WEIGHT_BITS];
      p  = PW'(xi) * PW'(wi);
      if (mask[j]) sum = sum + ACC_BITS'(p);
    end
  end

endmodule

// File: rtl/node_seq.sv
// Time-multiplexed neuron: LANES MACs per beat onto a bias, then quantising activation.
// out_valid rises BEATS+1 edges after acceptance; result held until out_ready, in_ready low while busy.
module node_seq
  import node_pkg::*;
#(
  parameter int N_INPUTS    = 16,
  parameter int LANES       = 4,
  parameter int INPUT_BITS  = 3,
  parameter int WEIGHT_BITS = 3,
  parameter int ACC_BITS    = 16,
  parameter int SHIFT       = 2,
  parameter int OUTPUT_BITS = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_INPUTS*INPUT_BITS-1:0]  inputs_t,
  input  logic [N_INPUTS*WEIGHT_BITS-1:0] weights_t,
  input  logic [WEIGHT_BITS-1:0]          bias_t,
  input  logic                            act_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUTPUT_BITS-1:0]          outputs_t,
  output logic                            sat
);

  localparam int BEATS = beats(N_INPUTS, LANES);
  localparam int BW    = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int XW    = BEATS * LANES * INPUT_BITS;
  localparam int WW    = BEATS * LANES * WEIGHT_BITS;
  localparam logic signed [31:0] OMAX = (1 <<< (OUTPUT_BITS - 1)) - 1;
  localparam logic signed [31:0] OMIN = -(1 <<< (OUTPUT_BITS - 1));

  state_t                      state;
  logic [XW-1:0]               in_q;
  logic [WW-1:0]               w_q;
  logic                        mode_q;
  logic [BW-1:0]               beat;
  logic signed [ACC_BITS-1:0]  acc;
  logic signed [ACC_BITS-1:0]  part;
  logic [LANES-1:0]            mask;
  logic signed [ACC_BITS-1:0]  s;
  logic signed [31:0]          s32;
  logic signed [31:0]          clamped;
  logic                        sat_n;

  // Captured vectors are zero-padded to a whole number of beats; the mask
  // additionally keeps the padding lanes out of the sum.
  always_comb begin
    mask = '0;
    for (int j = 0; j < LANES; j++)
      mask[j] = (int'(beat) * LANES + j) < N_INPUTS;
  end

  mac_lanes #(
    .LANES       (LANES),
    .INPUT_BITS  (INPUT_BITS),
    .WEIGHT_BITS (WEIGHT_BITS),
    .ACC_BITS    (ACC_BITS)
  ) u_mac (
    .x    (in_q[int'(beat)*LANES*INPUT_BITS +: LANES*INPUT_BITS]),
    .w    (w_q[int'(beat)*LANES*WEIGHT_BITS +: LANES*WEIGHT_BITS]),
    .mask (mask),
    .sum  (part)
  );

  always_comb begin
    s   = acc >>> SHIFT;
    s32 = 32'(s);
    if (mode_q) begin
      clamped = (s32 < 0) ? 32'sd0 : sclamp(s32, 32'sd0, OMAX);
      sat_n   = (s32 < 0) ? 1'b0 : (clamped != s32);
    end else begin
      clamped = sclamp(s32, OMIN, OMAX);
      sat_n   = (clamped != s32);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      outputs_t <= '0;
      sat       <= 1'b0;
      acc       <= '0;
      beat      <= '0;
      in_q      <= '0;
      w_q       <= '0;
      mode_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_q     <= XW'(inputs_t);
            w_q      <= WW'(weights_t);
            mode_q   <= act_mode;
            acc      <= ACC_BITS'(signed'(bias_t));
            beat     <= '0;
            in_ready <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + part;
          if (beat == BW'(BEATS - 1)) state <= ACT;
          else                        beat  <= beat + 1'b1;
        end
        ACT: begin
          outputs_t <= OUTPUT_BITS'(clamped);
          sat       <= sat_n;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          // in_ready returns only after the consuming edge, so no same-cycle reuse.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_node_seq.sv
// Directed bench for node_seq: default 16x4 instance plus a 6-input/4-lane partial-beat instance.
module tb_node_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        in_valid_a, in_ready_a, act_mode_a, out_valid_a, out_ready_a, sat_a;
  logic [47:0] inputs_a, weights_a;
  logic [2:0]  bias_a, out_a;

  logic        in_valid_b, in_ready_b, act_mode_b, out_valid_b, out_ready_b, sat_b;
  logic [17:0] inputs_b, weights_b;
  logic [2:0]  bias_b, out_b;

  int n_tests = 0;
  int n_fail  = 0;

  node_seq u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .inputs_t(inputs_a), .weights_t(weights_a), .bias_t(bias_a), .act_mode(act_mode_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .outputs_t(out_a), .sat(sat_a)
  );

  node_seq #(.N_INPUTS(6), .LANES(4), .SHIFT(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .inputs_t(inputs_b), .weights_t(weights_b), .bias_t(bias_b), .act_mode(act_mode_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .outputs_t(out_b), .sat(sat_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] rep(input logic [2:0] v);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*3 +: 3] = v;
    return r;
  endfunction

  // Offer a vector on instance b=0 (a) or b=1 (b); returns 1 ns after the accepting edge
  // with the inputs scrambled so only captured copies can produce the right answer.
  task automatic send(input bit b, input logic [47:0] x, input logic [47:0] w,
                      input logic [2:0] bias, input logic m);
    @(negedge clk);
    chk(b ? "b_rdy_idle" : "a_rdy_idle", b ? in_ready_b : in_ready_a, 1);
    if (b) begin
      inputs_b = 18'(x); weights_b = 18'(w); bias_b = bias; act_mode_b = m; in_valid_b = 1'b1;
    end else begin
      inputs_a = x; weights_a = w; bias_a = bias; act_mode_a = m; in_valid_a = 1'b1;
    end
    @(posedge clk);
    #1;
    if (b) begin
      in_valid_b = 1'b0;
      inputs_b = 18'($urandom()); weights_b = 18'($urandom()); bias_b = 3'($urandom()); act_mode_b = ~m;
    end else begin
      in_valid_a = 1'b0;
      inputs_a = 48'({$urandom(), $urandom()}); weights_a = 48'({$urandom(), $urandom()});
      bias_a = 3'($urandom()); act_mode_a = ~m;
    end
  endtask

  task automatic wait_res(input bit b, input string tag, input int lat,
                          input logic [2:0] eo, input logic es);
    int n;
    n = 0;
    @(negedge clk);
    while (!(b ? out_valid_b : out_valid_a) && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"},  n, lat);
    chk({tag, "_out"},  b ? out_b : out_a, eo);
    chk({tag, "_sat"},  b ? sat_b : sat_a, es);
    chk({tag, "_busy"}, b ? in_ready_b : in_ready_a, 0);
    if (b) out_ready_b = 1'b1; else out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    @(negedge clk);
    chk({tag, "_drop"}, b ? out_valid_b : out_valid_a, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset = 1'b1;
    in_valid_a = 0; act_mode_a = 0; out_ready_a = 0; inputs_a = '0; weights_a = '0; bias_a = '0;
    in_valid_b = 0; act_mode_b = 0; out_ready_b = 0; inputs_b = '0; weights_b = '0; bias_b = '0;
    #3;
    chk("rst_a_in_ready", in_ready_a, 1);
    chk("rst_a_out_valid", out_valid_a, 0);
    chk("rst_a_out", out_a, 0);
    chk("rst_a_sat", sat_a, 0);
    chk("rst_b_in_ready", in_ready_b, 1);
    chk("rst_b_out_valid", out_valid_b, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Default instance: BEATS=4, SHIFT=2, latency 5.
    send(0, rep(3'd1), rep(3'd1), 3'd0, 1'b0);  wait_res(0, "sat_pos",   5, 3'b011, 1'b1);
    send(0, rep(3'd1), rep(3'd7), 3'd0, 1'b0);  wait_res(0, "neg_clamp", 5, 3'b100, 1'b0);
    send(0, rep(3'd1), rep(3'd7), 3'd0, 1'b1);  wait_res(0, "neg_relu",  5, 3'b000, 1'b0);
    send(0, 48'd3,     48'd2,     3'd2, 1'b0);  wait_res(0, "bias_one",  5, 3'b010, 1'b0);
    send(0, rep(3'd1), rep(3'd1), 3'd0, 1'b1);  wait_res(0, "relu_sat",  5, 3'b011, 1'b1);
    send(0, rep(3'd3), rep(3'd4), 3'd0, 1'b0);  wait_res(0, "neg_sat",   5, 3'b100, 1'b1);
    send(0, 48'd0,     48'd0,     3'd4, 1'b0);  wait_res(0, "bias_neg",  5, 3'b111, 1'b0);

    // Partial last beat: 6 inputs over 4 lanes, SHIFT=0, latency 3.
    send(1, rep(3'd1), rep(3'd1), 3'd0, 1'b0);  wait_res(1, "part_sat",  3, 3'd3, 1'b1);
    send(1, 48'd3 << 15, 48'd6 << 15, 3'd0, 1'b0); wait_res(1, "part_e5", 3, 3'b100, 1'b1);
    send(1, 48'd7 << 12, 48'd1 << 12, 3'd1, 1'b0); wait_res(1, "part_e4", 3, 3'd0, 1'b0);

    // Backpressure: result held 10 cycles while a second vector is offered and ignored.
    send(0, rep(3'd1), rep(3'd1), 3'd0, 1'b0);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid_a && n < 20) begin
        @(posedge clk); n++; @(negedge clk);
      end
      chk("bp_lat", n, 5);
    end
    for (int k = 0; k < 10; k++) begin
      inputs_a = 48'd3; weights_a = 48'd2; bias_a = 3'd2; act_mode_a = 1'b0; in_valid_a = 1'b1;
      chk("bp_valid", out_valid_a, 1);
      chk("bp_out", out_a, 3'b011);
      chk("bp_sat", sat_a, 1);
      chk("bp_in_ready", in_ready_a, 0);
      @(negedge clk);
    end
    out_ready_a = 1'b1;
    @(posedge clk);
    #1 out_ready_a = 1'b0;
    @(negedge clk);
    chk("bp_consumed", out_valid_a, 0);
    chk("bp_ready_next", in_ready_a, 1);
    @(posedge clk);
    #1 in_valid_a = 1'b0;
    inputs_a = rep(3'd5); weights_a = rep(3'd5);
    wait_res(0, "bp_second", 5, 3'b010, 1'b0);

    // Asynchronous reset during beat 2 of ACCUM.
    send(0, rep(3'd1), rep(3'd1), 3'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready_a, 1);
    chk("rst_mid_out_valid", out_valid_a, 0);
    chk("rst_mid_out", out_a, 0);
    chk("rst_mid_sat", sat_a, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | out_valid_a;
    end
    chk("rst_no_emit", seen, 0);
    send(0, 48'd3, 48'd2, 3'd2, 1'b0);  wait_res(0, "rst_after", 5, 3'b010, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
